// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver:
// FIFO depth default and 7-segment patterns.
`timescale 1ns/1ps
package ps2_pkg;

  localparam int PS2_FIFO_DEPTH = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low g..a patterns, digit F first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd7seg.sv
// Hex digit to active-low 7-segment pattern.
`timescale 1ns/1ps
module bcd7seg
  import ps2_pkg::*;
(
  input  logic [3:0] b,
  output logic [6:0] h
);

  assign h = SEG_TABLE[b];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver with show-ahead FIFO and hex display.
// Optional odd-parity validation: define PS2_PARITY_CHECK_EN.
`timescale 1ns/1ps
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = PS2_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       sampling,
  output logic [6:0] h1,
  output logic [6:0] h2
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]    sync;
  logic          fall;
  logic [3:0]    count;
  logic [9:0]    buffer;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          frame_end;
  logic          frame_ok;
  logic          parity_ok;
  logic [6:0]    seg_lo;
  logic [6:0]    seg_hi;

  assign fall      = sync[2] & ~sync[1];
  assign frame_end = fall & (count == 4'd10);

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^buffer[9:1];
`else
  logic unused_parity;
  assign parity_ok     = 1'b1;
  assign unused_parity = buffer[9];
`endif

  assign frame_ok = ~buffer[0] & ps2_data & parity_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign pop  = ~nextdata_n & ~empty;
  assign push = frame_end & frame_ok & (~full | pop);
  assign drop = frame_end & frame_ok & full & ~pop;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      sync     <= 3'b111;
      sampling <= 1'b0;
      count    <= 4'd0;
      buffer   <= 10'd0;
    end else begin
      sync     <= {sync[1:0], ps2_clk};
      sampling <= fall;
      if (fall) begin
        if (count == 4'd10) begin
          count <= 4'd0;
        end else begin
          buffer[count] <= ps2_data;
          count         <= count + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= buffer[8:1];
        wptr              <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign data  = mem[rptr[AW-1:0]];
  assign ready = ~empty;

  bcd7seg u_seg_lo (
    .b (data[3:0]),
    .h (seg_lo)
  );

  bcd7seg u_seg_hi (
    .b (data[7:4]),
    .h (seg_hi)
  );

  assign h1 = ready ? seg_lo : SEG_BLANK;
  assign h2 = ready ? seg_hi : SEG_BLANK;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised bench for ps2_keyboard_rx against a queue-based model.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int DEPTH = 8;
  localparam int HALF  = 150;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       sampling;
  logic [6:0] h1;
  logic [6:0] h2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q[$];
  logic       m_ovf;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .sampling   (sampling),
    .h1         (h1),
    .h2         (h2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79;
      4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12;
      4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10;
      4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21;
      4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ready"}, 32'(ready), 32'(q.size() != 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) begin
      check({tag, ".data"}, 32'(data), 32'(q[0]));
      check({tag, ".h1"}, 32'(h1), 32'(seg(q[0][3:0])));
      check({tag, ".h2"}, 32'(h2), 32'(seg(q[0][7:4])));
    end else begin
      check({tag, ".h1"}, 32'(h1), 32'h7F);
      check({tag, ".h2"}, 32'(h2), 32'h7F);
    end
  endtask

  // Model: a frame is accepted when framing (and optionally parity) holds.
  task automatic model_frame(input logic [7:0] b, input bit st,
                             input bit sp, input bit par);
    bit ok;
    ok = (st == 1'b0) && (sp == 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && ((^b ^ par) == 1'b1);
`endif
    if (ok) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit st,
                            input bit sp, input bit par);
    logic [10:0] bits;
    bit seen;
    int k;
    bits = {sp, par, b, st};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      #(HALF);
      ps2_clk = 1'b0;
      if (i == 10) begin
        seen = 0;
        k = 0;
        while (!seen && k < 20) begin
          @(negedge clk);
          seen = sampling;
          k++;
        end
        check("sampling", 32'(seen), 32'd1);
        model_frame(b, st, sp, par);
        repeat (2) @(negedge clk);
        check("ready_2clk", 32'(ready), 32'(q.size() != 0));
      end
      #(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    #(HALF);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, ~^b);
  endtask

  task automatic pop_one();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    clrn = 1'b1;
    #2;
    q.delete();
    m_ovf = 1'b0;
    check({tag, ".ready"}, 32'(ready), 32'd0);
    check({tag, ".data"}, 32'(data), 32'd0);
    check({tag, ".h1"}, 32'(h1), 32'h7F);
    check({tag, ".h2"}, 32'(h2), 32'h7F);
    check({tag, ".ovf"}, 32'(overflow), 32'd0);
    check({tag, ".samp"}, 32'(sampling), 32'd0);
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    clrn       = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    m_ovf      = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("rst");

    send_good(8'h1C);
    check_all("f1C");
    check("f1C.h1", 32'(h1), 32'h46);
    check("f1C.h2", 32'(h2), 32'h79);
    pop_one();
    check_all("pop1C");

    send_good(8'h1C);
    send_good(8'hF0);
    send_good(8'h1C);
    check_all("seq0");
    for (int i = 1; i <= 3; i++) begin
      pop_one();
      check_all($sformatf("seq%0d", i));
    end
    pop_one();
    check_all("popempty");

    send_frame(8'h33, 1'b0, 1'b0, ~^8'h33);
    check_all("badstop");
    send_good(8'h5A);
    check_all("f5A");
    pop_one();

    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check_all("badpar");
    pop_one();
    check_all("badpar.pop");

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 5);
      b = 8'($urandom);
      send_frame(b, kind == 4, kind != 2,
                 (kind == 3) ? ^b : ~^b);
      check_all($sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) != 0) begin
        pop_one();
        check_all($sformatf("rndpop%0d", n));
      end
    end

    do_reset("rst2");
    for (int n = 0; n < DEPTH + 1; n++) begin
      send_good(8'($urandom));
    end
    check_all("ovf");
    for (int n = 0; n < DEPTH; n++) begin
      pop_one();
      check_all($sformatf("ovfpop%0d", n));
    end
    check("ovf.sticky", 32'(overflow), 32'd1);

    for (int i = 0; i < 5; i++) begin
      ps2_data = i[0];
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
    end
    do_reset("rst3");
    send_good(8'h29);
    check_all("f29");
    check("f29.data", 32'(data), 32'h29);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive-FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-003 SHALL have port clrn, input, 1 bit: reset, asynchronous and active-high (1 = clear).
REQ-004 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock, asynchronous, idle high.
REQ-005 SHALL have port ps2_data, input, 1 bit: raw PS/2 data, asynchronous, idle high.
REQ-006 SHALL have port nextdata_n, input, 1 bit: active-low pop request.
REQ-007 SHALL have port data, output, 8 bits: oldest FIFO byte (show-ahead).
REQ-008 SHALL have port ready, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port overflow, output, 1 bit: sticky, a frame was dropped because FIFO was full.
REQ-010 SHALL have port sampling, output, 1 bit: one-clk pulse per detected ps2_clk falling edge.
REQ-011 SHALL have ports h1 and h2, output, 7 bits each: active-low 7-seg of data[3:0] and data[7:4], bit0=a..bit6=g.

Function
REQ-012 SHALL synchronise ps2_clk through a 3-flop chain; falling edge = previous synced 1, current synced 0.
REQ-013 SHALL, on each falling edge, sample ps2_data into bit position count of a 10-bit shift buffer and increment count (0..10).
REQ-014 SHALL, on the 11th edge (count==10), validate frame: start bit buffer[0]==0, stop bit ps2_data==1; then reset count to 0.
REQ-015 SHALL write buffer[8:1] into FIFO in the validation cycle if valid and FIFO not full; ready rises on the next clk.
REQ-016 SHALL silently discard invalid frames; overflow, pointers unchanged.
REQ-017 SHALL, on a valid frame with FIFO full, drop the frame and set overflow; overflow stays 1 until reset.
REQ-018 SHALL pop one entry on every clk edge where nextdata_n==0 and ready==1; nextdata_n==0 when empty is ignored.
REQ-019 SHALL handle simultaneous write and pop in one cycle: both occur, occupancy unchanged; full-with-pop counts as not full.
REQ-020 SHALL use read/write pointers of log2(FIFO_DEPTH)+1 bits; empty = equal, full = MSB differ, rest equal; pointers wrap.
REQ-021 SHALL drive data combinationally from FIFO[read pointer]; value undefined-free (0) after reset.
REQ-022 SHALL decode h1/h2 hex 0-F active-low: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, g..a).
REQ-023 SHALL blank h1 and h2 (7'h7F) while ready==0.

Reset
REQ-024 SHALL, with clrn==1, immediately clear count, buffer, sync chain (to 1s), pointers, overflow, sampling; ready=0, data=0, h1=h2=7'h7F.
REQ-025 SHALL abandon any partial frame on reset; first edge after release is treated as a start bit.

Configuration
REQ-026 SHALL support macro PS2_PARITY_CHECK_EN: when defined, a frame is valid only if additionally XOR of buffer[9:1] == 1 (odd parity); when undefined, the parity bit is ignored.

Structure
REQ-027 SHALL place FIFO_DEPTH default, segment pattern table and blank constant (7'h7F) in package ps2_pkg.
REQ-028 SHALL implement the hex decoder as sub-module bcd7seg (4-bit in b, 7-bit out h), instantiated twice.

Verification
REQ-029 Send 0x1C frame (start 0, LSB-first, parity 0, stop 1) -> ready=1 within 2 clk of 11th edge, data=0x1C, h1=7'h46, h2=7'h79.
REQ-030 Send 0x1C,0xF0,0x1C, pulse nextdata_n low one clk each -> data 0x1C,0xF0,0x1C in order, then ready=0, h1=h2=7'h7F.
REQ-031 Send 9 valid frames without popping (FIFO_DEPTH=8) -> overflow=1, 8 bytes pop back correct, 9th absent; overflow stays 1.
REQ-032 Send frame with stop bit 0 -> ready stays 0; next valid frame 0x5A received correctly.
REQ-033 With PS2_PARITY_CHECK_EN, send 0x1C with parity 1 -> discarded; without macro -> accepted.
REQ-034 Assert clrn after 5 bits of a frame -> all outputs reset; following full frame 0x29 received as 0x29.
